// File: rtl/game_fsm.sv
// Game-flow controller: synchronized/debounced flap button, READY/PLAY/DYING/OVER
// sequencing and high-score tracking across games since reset.
module game_fsm #(
    parameter int DB_MS  = 10,
    parameter int DIE_MS = 1000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tick_ms,
    input  logic       up_button,
    input  logic       is_dead,
    input  logic [7:0] score,
    output logic [1:0] state,
    output logic       flap,
    output logic [7:0] high_score,
    output logic       new_record
);

    localparam int DBW = $clog2(DB_MS) + 1;
    localparam int DW  = $clog2(DIE_MS) + 1;
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_MS - 1);
    localparam logic [DBW-1:0] DB_ONE   = DBW'(1);
    localparam logic [DW-1:0]  DIE_LAST = DW'(DIE_MS - 1);
    localparam logic [DW-1:0]  DIE_ONE  = DW'(1);

    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_PLAY  = 2'b01,
        ST_DYING = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    logic           sync1_q, sync2_q;
    logic           db_q, db_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           press_s;
    state_e         state_q, state_d;
    logic           flap_q, flap_d;
    logic [DW-1:0]  die_cnt_q, die_cnt_d, die_inc_s;
    logic [7:0]     high_score_q, high_score_d;
    logic           new_record_q, new_record_d;

    assign die_inc_s = die_cnt_q + DIE_ONE;

    // Debounce: the level flips on the DB_MS-th consecutive differing tick; press is the 0->1 flip.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        press_s  = 1'b0;
        if (tick_ms) begin
            if (sync2_q != db_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_d     = sync2_q;
                    db_cnt_d = {DBW{1'b0}};
                    press_s  = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end else begin
                db_cnt_d = {DBW{1'b0}};
            end
        end else begin
            db_cnt_d = db_cnt_q;
        end
    end

    // Game state sequencing, flap request and end-of-game record update.
    always_comb begin
        state_d      = state_q;
        flap_d       = 1'b0;
        die_cnt_d    = die_cnt_q;
        high_score_d = high_score_q;
        new_record_d = new_record_q;
        case (state_q)
            ST_READY: begin
                if (press_s) begin
                    state_d      = ST_PLAY;
                    flap_d       = 1'b1;
                    new_record_d = 1'b0;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_PLAY: begin
                if (is_dead) begin
                    state_d   = ST_DYING;
                    die_cnt_d = {DW{1'b0}};
                end else if (press_s) begin
                    flap_d = 1'b1;
                end else begin
                    flap_d = 1'b0;
                end
            end
            ST_DYING: begin
                if (tick_ms) begin
                    die_cnt_d = die_inc_s;
                    if (die_inc_s >= DIE_LAST) begin
                        state_d = ST_OVER;
                        if (score > high_score_q) begin
                            high_score_d = score;
                            new_record_d = 1'b1;
                        end else begin
                            new_record_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_DYING;
                    end
                end else begin
                    die_cnt_d = die_cnt_q;
                end
            end
            ST_OVER: begin
                if (press_s) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // State registers; the first two flops form the button synchronizer.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_q         <= 1'b0;
            db_cnt_q     <= {DBW{1'b0}};
            state_q      <= ST_READY;
            flap_q       <= 1'b0;
            die_cnt_q    <= {DW{1'b0}};
            high_score_q <= 8'd0;
            new_record_q <= 1'b0;
        end else begin
            sync1_q      <= up_button;
            sync2_q      <= sync1_q;
            db_q         <= db_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            flap_q       <= flap_d;
            die_cnt_q    <= die_cnt_d;
            high_score_q <= high_score_d;
            new_record_q <= new_record_d;
        end
    end

    assign state      = state_q;
    assign flap       = flap_q;
    assign high_score = high_score_q;
    assign new_record = new_record_q;

endmodule

// File: tb/tb_game_fsm.sv
// Bench for game_fsm: directed scenarios plus randomized play checked against a rule-level model.
module tb_game_fsm;

    localparam int DB_MS  = 2;
    localparam int DIE_MS = 5;

    logic       clk       = 1'b0;
    logic       clrn      = 1'b0;
    logic       tick_ms   = 1'b0;
    logic       up_button = 1'b0;
    logic       is_dead   = 1'b0;
    logic [7:0] score     = 8'd0;
    logic [1:0] state;
    logic       flap;
    logic [7:0] high_score;
    logic       new_record;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    game_fsm #(.DB_MS(DB_MS), .DIE_MS(DIE_MS)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .tick_ms    (tick_ms),
        .up_button  (up_button),
        .is_dead    (is_dead),
        .score      (score),
        .state      (state),
        .flap       (flap),
        .high_score (high_score),
        .new_record (new_record)
    );

    always #5 clk = ~clk;

    // 1 ms tick stand-in: one pulse every 4 clocks, changed just after the rising edge
    always @(posedge clk) begin
        #1;
        cyc     = cyc + 1;
        tick_ms = (cyc % 4 == 0);
    end

    // Reference model: game rules evaluated once per rising edge
    bit         m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0;
    int         m_dbc = 0, m_die = 0;
    logic [1:0] m_st = 2'd0;
    bit         m_flap = 1'b0;
    logic [7:0] m_hs = 8'd0;
    bit         m_nr = 1'b0;

    always @(posedge clk or negedge clrn) begin : model
        bit pr;
        int dbc;
        if (!clrn) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_db <= 1'b0; m_dbc <= 0; m_die <= 0;
            m_st <= 2'd0; m_flap <= 1'b0; m_hs <= 8'd0; m_nr <= 1'b0;
        end else begin
            pr  = 1'b0;
            dbc = m_dbc;
            if (tick_ms) begin
                if (m_s2 != m_db) begin
                    dbc = dbc + 1;
                    if (dbc == DB_MS) begin
                        dbc = 0;
                        pr  = m_s2;
                        m_db <= m_s2;
                    end
                end else begin
                    dbc = 0;
                end
            end
            m_dbc  <= dbc;
            m_s2   <= m_s1;
            m_s1   <= up_button;
            m_flap <= 1'b0;
            case (m_st)
                2'd0: if (pr) begin m_st <= 2'd1; m_flap <= 1'b1; m_nr <= 1'b0; end
                2'd1: if (is_dead) begin m_st <= 2'd2; m_die <= 0; end
                      else if (pr) m_flap <= 1'b1;
                2'd2: if (tick_ms) begin
                          m_die <= m_die + 1;
                          if (m_die + 1 >= DIE_MS - 1) begin
                              m_st <= 2'd3;
                              if (score > m_hs) begin m_hs <= score; m_nr <= 1'b1; end
                              else m_nr <= 1'b0;
                          end
                      end
                default: if (pr) m_st <= 2'd0;
            endcase
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push();
        up_button = 1'b1; adv(16);
        up_button = 1'b0; adv(16);
    endtask

    task automatic test_reset();
        clrn = 1'b0; adv(3);
        n_vec++;
        if ({state, flap, high_score, new_record} !== 12'h000) begin
            n_err++;
            $display("FAIL reset: got %h, want 000", {state, flap, high_score, new_record});
        end
        clrn = 1'b1; adv(2);
    endtask

    task automatic test_glitch();
        up_button = 1'b1; adv(4);
        up_button = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            n_vec++;
            if (flap !== 1'b0 || state !== 2'b00) begin
                n_err++;
                $display("FAIL glitch: got state=%b flap=%b, want 00/0", state, flap);
            end
        end
    endtask

    task automatic test_press();
        int flaps = 0;
        up_button = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (flap === 1'b1) begin
                flaps++;
                n_vec++;
                if (state !== 2'b01) begin
                    n_err++;
                    $display("FAIL flap_with_play: got state=%b, want 01", state);
                end
            end
        end
        up_button = 1'b0; adv(20);
        n_vec++;
        if (flaps != 1) begin n_err++; $display("FAIL press_flaps: got %0d, want 1", flaps); end
        n_vec++;
        if (state !== 2'b01) begin n_err++; $display("FAIL press_state: got %b, want 01", state); end
    endtask

    task automatic test_death_record();
        bit found = 1'b0;
        score = 8'd7;
        up_button = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (tick_ms && m_s2 && !m_db && m_dbc == DB_MS - 1) begin
                is_dead = 1'b1;
                found   = 1'b1;
            end
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL press_align: got no press slot, want one"); end
        @(negedge clk);
        is_dead = 1'b0;
        n_vec++;
        if (state !== 2'b10 || flap !== 1'b0) begin
            n_err++;
            $display("FAIL dead_wins: got state=%b flap=%b, want 10/0", state, flap);
        end
        adv(24);
        n_vec++;
        if ({state, high_score, new_record} !== {2'b11, 8'd7, 1'b1}) begin
            n_err++;
            $display("FAIL game1_end: got st=%b hs=%0d nr=%b, want 11/7/1", state, high_score, new_record);
        end
    endtask

    task automatic test_games();
        up_button = 1'b0; adv(16);
        push();
        n_vec++;
        if (state !== 2'b00 || new_record !== 1'b1) begin
            n_err++;
            $display("FAIL record_hold: got st=%b nr=%b, want 00/1", state, new_record);
        end
        push();
        n_vec++;
        if (state !== 2'b01 || new_record !== 1'b0) begin
            n_err++;
            $display("FAIL record_clear: got st=%b nr=%b, want 01/0", state, new_record);
        end
        score = 8'd7; is_dead = 1'b1; adv(1); is_dead = 1'b0; adv(24);
        n_vec++;
        if ({state, high_score, new_record} !== {2'b11, 8'd7, 1'b0}) begin
            n_err++;
            $display("FAIL equal_score: got st=%b hs=%0d nr=%b, want 11/7/0", state, high_score, new_record);
        end
        push(); push();
        score = 8'd9; is_dead = 1'b1; adv(1); is_dead = 1'b0; adv(24);
        n_vec++;
        if ({state, high_score, new_record} !== {2'b11, 8'd9, 1'b1}) begin
            n_err++;
            $display("FAIL higher_score: got st=%b hs=%0d nr=%b, want 11/9/1", state, high_score, new_record);
        end
    endtask

    task automatic test_hold();
        int  flaps = 0;
        bit  saw_play = 1'b0;
        up_button = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (flap === 1'b1) flaps++;
            if (state === 2'b01) saw_play = 1'b1;
        end
        n_vec++;
        if (state !== 2'b00 || flaps != 0 || saw_play) begin
            n_err++;
            $display("FAIL hold: got st=%b flaps=%0d play=%0d, want 00/0/0", state, flaps, saw_play);
        end
        up_button = 1'b0; adv(16);
        push();
        n_vec++;
        if (state !== 2'b01) begin n_err++; $display("FAIL repress: got %b, want 01", state); end
    endtask

    task automatic test_reset_mid();
        int flaps = 0;
        is_dead = 1'b1; adv(1); is_dead = 1'b0; adv(4);
        n_vec++;
        if (state !== 2'b10 || high_score !== 8'd9) begin
            n_err++;
            $display("FAIL pre_reset: got st=%b hs=%0d, want 10/9", state, high_score);
        end
        up_button = 1'b1;
        clrn = 1'b0;
        #1;
        n_vec++;
        if ({state, flap, high_score, new_record} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_mid: got %h, want 000", {state, flap, high_score, new_record});
        end
        adv(2);
        clrn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (flap === 1'b1) flaps++;
        end
        n_vec++;
        if (flaps != 1 || state !== 2'b01) begin
            n_err++;
            $display("FAIL held_at_reset: got flaps=%0d st=%b, want 1/01", flaps, state);
        end
        up_button = 1'b0; adv(16);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_vec++;
            if ({state, flap, high_score, new_record} !== {m_st, m_flap, m_hs, m_nr}) begin
                n_err++;
                $display("FAIL random[%0d]: got st=%b f=%b hs=%0d nr=%b, want st=%b f=%b hs=%0d nr=%b",
                         i, state, flap, high_score, new_record, m_st, m_flap, m_hs, m_nr);
            end
            if ($urandom_range(0, 7) == 0) up_button = ~up_button;
            is_dead = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) score = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_death_record();
        test_games();
        test_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
